// File: rtl/mips_pkg.sv
// Shared constants and types for the pipelined MIPS execute stage.
package mips_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    // ALU operation codes driven onto ALU_Control
    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    // ALUOp encodings produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Forward-select codes
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Contents of the ID/EX pipeline register; all-zero is a bubble
    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          memto_reg;
        logic          mem_read;
        logic          mem_write;
        logic          reg_dst;
        logic          alu_src;
        logic [1:0]    alu_op;
        logic [DW-1:0] read_data1;
        logic [DW-1:0] read_data2;
        logic [DW-1:0] sign_ext;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
    } idex_t;

endpackage

// File: rtl/forwarding_unit.sv
// Combinational forward-select for the two EX source operands (rs, rt).
module forwarding_unit
    import mips_pkg::*;
(
    input  logic [RW-1:0] ex_Rs,
    input  logic [RW-1:0] ex_Rt,
    input  logic          mem_RegWrite,
    input  logic [RW-1:0] mem_WriteReg,
    input  logic          wb_RegWrite,
    input  logic [RW-1:0] wb_WriteReg,
    output logic [1:0]    ForwardA,
    output logic [1:0]    ForwardB
);

    logic [RW-1:0] src_idx [2];
    logic [1:0]    fwd_sel [2];

    assign src_idx[0] = ex_Rs;
    assign src_idx[1] = ex_Rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sel
            // MEM result is newer than WB, so it wins; $0 is hardwired and never forwarded
            always_comb begin
                fwd_sel[gi] = FWD_REG;
                if (mem_RegWrite && (mem_WriteReg != '0) && (mem_WriteReg == src_idx[gi])) begin
                    fwd_sel[gi] = FWD_MEM;
                end else if (wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == src_idx[gi])) begin
                    fwd_sel[gi] = FWD_WB;
                end
            end
        end
    endgenerate

    assign ForwardA = fwd_sel[0];
    assign ForwardB = fwd_sel[1];

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with forwarding, immediate select and ALU control decode.
module ex_operand_stage
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_RegWrite,
    input  logic          id_MemtoReg,
    input  logic          id_MemRead,
    input  logic          id_MemWrite,
    input  logic          id_RegDst,
    input  logic          id_ALUSrc,
    input  logic [1:0]    id_ALUOp,
    input  logic [DW-1:0] id_ReadData1,
    input  logic [DW-1:0] id_ReadData2,
    input  logic [DW-1:0] id_SignExt,
    input  logic [RW-1:0] id_Rs,
    input  logic [RW-1:0] id_Rt,
    input  logic [RW-1:0] id_Rd,
    input  logic          mem_RegWrite,
    input  logic [RW-1:0] mem_WriteReg,
    input  logic [DW-1:0] mem_ALUResult,
    input  logic          wb_RegWrite,
    input  logic [RW-1:0] wb_WriteReg,
    input  logic [DW-1:0] wb_WriteData,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [2:0]    ALU_Control,
    output logic [DW-1:0] ex_StoreData,
    output logic [RW-1:0] ex_WriteReg,
    output logic          ex_RegWrite,
    output logic          ex_MemtoReg,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic [RW-1:0] ex_Rs,
    output logic [RW-1:0] ex_Rt,
    output logic          ex_valid,
    output logic [1:0]    ForwardA,
    output logic [1:0]    ForwardB
);

    idex_t idex_q, idex_d;
    logic [DW-1:0] fwd_rs_val, fwd_rt_val;

    // Next ID/EX contents: flush inserts a bubble, stall holds, otherwise load from ID
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!stall) begin
            idex_d.valid      = 1'b1;
            idex_d.reg_write  = id_RegWrite;
            idex_d.memto_reg  = id_MemtoReg;
            idex_d.mem_read   = id_MemRead;
            idex_d.mem_write  = id_MemWrite;
            idex_d.reg_dst    = id_RegDst;
            idex_d.alu_src    = id_ALUSrc;
            idex_d.alu_op     = id_ALUOp;
            idex_d.read_data1 = id_ReadData1;
            idex_d.read_data2 = id_ReadData2;
            idex_d.sign_ext   = id_SignExt;
            idex_d.rs         = id_Rs;
            idex_d.rt         = id_Rt;
            idex_d.rd         = id_Rd;
        end
    end

    // ID/EX register; reset overrides stall and flush
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    forwarding_unit u_fwd (
        .ex_Rs        (idex_q.rs),
        .ex_Rt        (idex_q.rt),
        .mem_RegWrite (mem_RegWrite),
        .mem_WriteReg (mem_WriteReg),
        .wb_RegWrite  (wb_RegWrite),
        .wb_WriteReg  (wb_WriteReg),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB)
    );

    // Operand muxes track the live mem/wb inputs even while the register is stalled
    always_comb begin
        unique case (ForwardA)
            FWD_MEM: fwd_rs_val = mem_ALUResult;
            FWD_WB:  fwd_rs_val = wb_WriteData;
            default: fwd_rs_val = idex_q.read_data1;
        endcase
        unique case (ForwardB)
            FWD_MEM: fwd_rt_val = mem_ALUResult;
            FWD_WB:  fwd_rt_val = wb_WriteData;
            default: fwd_rt_val = idex_q.read_data2;
        endcase
    end

    assign A            = fwd_rs_val;
    assign ex_StoreData = fwd_rt_val;
    assign B            = idex_q.alu_src ? idex_q.sign_ext : fwd_rt_val;

    // ALU control from ALUOp, using the funct field of the immediate for R-type
    always_comb begin
        ALU_Control = ALU_ADD;
        case (idex_q.alu_op)
            ALUOP_ADD:  ALU_Control = ALU_ADD;
            ALUOP_SUB:  ALU_Control = ALU_SUB;
            ALUOP_SLTI: ALU_Control = ALU_SLT;
            default: begin
                case (idex_q.sign_ext[5:0])
                    FUNCT_ADD: ALU_Control = ALU_ADD;
                    FUNCT_SUB: ALU_Control = ALU_SUB;
                    FUNCT_AND: ALU_Control = ALU_AND;
                    FUNCT_OR:  ALU_Control = ALU_OR;
                    FUNCT_SLT: ALU_Control = ALU_SLT;
                    default:   ALU_Control = ALU_ADD;
                endcase
            end
        endcase
    end

    assign ex_WriteReg = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
    assign ex_RegWrite = idex_q.reg_write;
    assign ex_MemtoReg = idex_q.memto_reg;
    assign ex_MemRead  = idex_q.mem_read;
    assign ex_MemWrite = idex_q.mem_write;
    assign ex_Rs       = idex_q.rs;
    assign ex_Rt       = idex_q.rt;
    assign ex_valid    = idex_q.valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: driver pushes hand-computed expectations, monitor checks.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_RegDst, id_ALUSrc;
    logic [1:0]  id_ALUOp;
    logic [31:0] id_ReadData1, id_ReadData2, id_SignExt;
    logic [4:0]  id_Rs, id_Rt, id_Rd;
    logic        mem_RegWrite;
    logic [4:0]  mem_WriteReg;
    logic [31:0] mem_ALUResult;
    logic        wb_RegWrite;
    logic [4:0]  wb_WriteReg;
    logic [31:0] wb_WriteData;
    logic [31:0] A, B, ex_StoreData;
    logic [2:0]  ALU_Control;
    logic [4:0]  ex_WriteReg, ex_Rs, ex_Rt;
    logic        ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_valid;
    logic [1:0]  ForwardA, ForwardB;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
        .id_ALUOp(id_ALUOp), .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
        .id_SignExt(id_SignExt), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rd(id_Rd),
        .mem_RegWrite(mem_RegWrite), .mem_WriteReg(mem_WriteReg), .mem_ALUResult(mem_ALUResult),
        .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg), .wb_WriteData(wb_WriteData),
        .A(A), .B(B), .ALU_Control(ALU_Control), .ex_StoreData(ex_StoreData),
        .ex_WriteReg(ex_WriteReg), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Rs(ex_Rs), .ex_Rt(ex_Rt),
        .ex_valid(ex_valid), .ForwardA(ForwardA), .ForwardB(ForwardB)
    );

    // ctrl order: {RegWrite, MemtoReg, MemRead, MemWrite, RegDst, ALUSrc}
    typedef struct {
        logic        rst, stall, flush;
        logic [5:0]  ctrl;
        logic [1:0]  aluop;
        logic [31:0] rd1, rd2, sext;
        logic [4:0]  rs, rt, rd;
        logic        mrw;
        logic [4:0]  mwr;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wwr;
        logic [31:0] wdata;
    } stim_t;

    // ctrl4 order: {RegWrite, MemtoReg, MemRead, MemWrite}
    typedef struct {
        string       name;
        logic [31:0] a, b, store;
        logic [2:0]  aluc;
        logic [4:0]  wreg, rs, rt;
        logic [3:0]  ctrl4;
        logic        valid;
        logic [1:0]  fa, fb;
    } exp_t;

    exp_t exp_q [$];
    int   tests  = 0;
    int   failed = 0;
    bit   drv_done = 1'b0;

    function automatic stim_t st(logic r, logic s, logic f, logic [5:0] c, logic [1:0] op,
                                 logic [31:0] d1, logic [31:0] d2, logic [31:0] se,
                                 logic [4:0] rs_, logic [4:0] rt_, logic [4:0] rd_);
        stim_t v;
        v.rst = r; v.stall = s; v.flush = f; v.ctrl = c; v.aluop = op;
        v.rd1 = d1; v.rd2 = d2; v.sext = se; v.rs = rs_; v.rt = rt_; v.rd = rd_;
        v.mrw = 1'b0; v.mwr = '0; v.mres = '0; v.wrw = 1'b0; v.wwr = '0; v.wdata = '0;
        return v;
    endfunction

    function automatic stim_t fw(stim_t v, logic mrw, logic [4:0] mwr, logic [31:0] mres,
                                 logic wrw, logic [4:0] wwr, logic [31:0] wd);
        stim_t o = v;
        o.mrw = mrw; o.mwr = mwr; o.mres = mres; o.wrw = wrw; o.wwr = wwr; o.wdata = wd;
        return o;
    endfunction

    function automatic exp_t ex(string n, logic [31:0] a, logic [31:0] b, logic [2:0] aluc,
                                logic [31:0] store, logic [4:0] wreg, logic [3:0] c4,
                                logic [4:0] rs_, logic [4:0] rt_, logic v,
                                logic [1:0] fa, logic [1:0] fb);
        exp_t e;
        e.name = n; e.a = a; e.b = b; e.aluc = aluc; e.store = store; e.wreg = wreg;
        e.ctrl4 = c4; e.rs = rs_; e.rt = rt_; e.valid = v; e.fa = fa; e.fb = fb;
        return e;
    endfunction

    task automatic apply(stim_t v);
        rst = v.rst; stall = v.stall; flush = v.flush;
        {id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_RegDst, id_ALUSrc} = v.ctrl;
        id_ALUOp = v.aluop; id_ReadData1 = v.rd1; id_ReadData2 = v.rd2; id_SignExt = v.sext;
        id_Rs = v.rs; id_Rt = v.rt; id_Rd = v.rd;
        mem_RegWrite = v.mrw; mem_WriteReg = v.mwr; mem_ALUResult = v.mres;
        wb_RegWrite = v.wrw; wb_WriteReg = v.wwr; wb_WriteData = v.wdata;
    endtask

    // One vector: drive mid-cycle, let the edge capture, then publish the expectation
    task automatic vec(stim_t v, exp_t e);
        @(negedge clk); #1;
        apply(v);
        @(posedge clk); #1;
        exp_q.push_back(e);
    endtask

    function automatic void chk(string n, string f, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", n, f, act, req);
        end
    endfunction

    // Monitor: the DUT presents a fresh output set every cycle; check on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "A", A, e.a);
                chk(e.name, "B", B, e.b);
                chk(e.name, "ALU_Control", 32'(ALU_Control), 32'(e.aluc));
                chk(e.name, "StoreData", ex_StoreData, e.store);
                chk(e.name, "WriteReg", 32'(ex_WriteReg), 32'(e.wreg));
                chk(e.name, "ctrl", 32'({ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite}), 32'(e.ctrl4));
                chk(e.name, "Rs", 32'(ex_Rs), 32'(e.rs));
                chk(e.name, "Rt", 32'(ex_Rt), 32'(e.rt));
                chk(e.name, "valid", 32'(ex_valid), 32'(e.valid));
                chk(e.name, "ForwardA", 32'(ForwardA), 32'(e.fa));
                chk(e.name, "ForwardB", 32'(ForwardB), 32'(e.fb));
                $display("[TB] checked %s", e.name);
            end
        end
    end

    // Driver: directed vectors with hand-computed results
    initial begin
        stim_t v;
        apply(st(1, 0, 0, 6'b0, 2'b00, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        // reset while ID presents a busy instruction
        vec(st(1, 0, 0, 6'b111111, 2'b10, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3),
            ex("reset", 0, 0, 3'd2, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 2'b00));
        // add $3,$1,$2
        v = st(0, 0, 0, 6'b100010, 2'b10, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3);
        vec(v, ex("add", 32'd5, 32'd7, 3'd2, 32'd7, 5'd3, 4'b1000, 5'd1, 5'd2, 1, 2'b00, 2'b00));
        // same add, both MEM and WB target $1: MEM wins
        vec(fw(v, 1, 5'd1, 32'd100, 1, 5'd1, 32'd200),
            ex("add_fwd_mem_prio", 32'd100, 32'd7, 3'd2, 32'd7, 5'd3, 4'b1000, 5'd1, 5'd2, 1, 2'b10, 2'b00));
        // WB alone to $1 while MEM targets an unrelated register
        vec(fw(v, 1, 5'd9, 32'd100, 1, 5'd1, 32'd200),
            ex("add_fwd_wb", 32'd200, 32'd7, 3'd2, 32'd7, 5'd3, 4'b1000, 5'd1, 5'd2, 1, 2'b01, 2'b00));
        // rs=$0: writers to $0 must not forward
        vec(fw(st(0, 0, 0, 6'b100010, 2'b10, 32'd0, 32'd7, 32'h20, 5'd0, 5'd2, 5'd3), 1, 5'd0, 32'd99, 1, 5'd0, 32'd77),
            ex("zero_reg_no_fwd", 32'd0, 32'd7, 3'd2, 32'd7, 5'd3, 4'b1000, 5'd0, 5'd2, 1, 2'b00, 2'b00));
        // sw $2,8($1) with rt forwarded from WB
        vec(fw(st(0, 0, 0, 6'b000101, 2'b00, 32'd10, 32'd3, 32'd8, 5'd1, 5'd2, 5'd0), 0, 0, 0, 1, 5'd2, 32'h55),
            ex("sw_fwd_wb", 32'd10, 32'd8, 3'd2, 32'h55, 5'd2, 4'b0001, 5'd1, 5'd2, 1, 2'b00, 2'b01));
        // stall twice with changing ID inputs; register holds sw, muxes follow live inputs
        vec(st(0, 1, 0, 6'b111111, 2'b10, 32'hDEAD, 32'hBEEF, 32'h2A, 5'd7, 5'd8, 5'd9),
            ex("stall1", 32'd10, 32'd8, 3'd2, 32'd3, 5'd2, 4'b0001, 5'd1, 5'd2, 1, 2'b00, 2'b00));
        vec(fw(st(0, 1, 0, 6'b110000, 2'b01, 32'h1111, 32'h2222, 32'h24, 5'd11, 5'd12, 5'd13), 1, 5'd1, 32'h1234, 0, 0, 0),
            ex("stall2_live_fwd", 32'h1234, 32'd8, 3'd2, 32'd3, 5'd2, 4'b0001, 5'd1, 5'd2, 1, 2'b10, 2'b00));
        // stall and flush together: bubble
        vec(st(0, 1, 1, 6'b111111, 2'b10, 32'hDEAD, 32'hBEEF, 32'h2A, 5'd7, 5'd8, 5'd9),
            ex("stall_flush", 0, 0, 3'd2, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 2'b00));
        // funct sweep
        vec(st(0, 0, 0, 6'b100010, 2'b10, 32'd1, 32'd2, 32'h24, 5'd4, 5'd5, 5'd6),
            ex("funct_and", 32'd1, 32'd2, 3'd0, 32'd2, 5'd6, 4'b1000, 5'd4, 5'd5, 1, 2'b00, 2'b00));
        vec(st(0, 0, 0, 6'b100010, 2'b10, 32'd1, 32'd2, 32'h25, 5'd4, 5'd5, 5'd6),
            ex("funct_or", 32'd1, 32'd2, 3'd1, 32'd2, 5'd6, 4'b1000, 5'd4, 5'd5, 1, 2'b00, 2'b00));
        vec(st(0, 0, 0, 6'b100010, 2'b10, 32'd1, 32'd2, 32'h2A, 5'd4, 5'd5, 5'd6),
            ex("funct_slt", 32'd1, 32'd2, 3'd7, 32'd2, 5'd6, 4'b1000, 5'd4, 5'd5, 1, 2'b00, 2'b00));
        vec(st(0, 0, 0, 6'b100010, 2'b10, 32'd1, 32'd2, 32'h22, 5'd4, 5'd5, 5'd6),
            ex("funct_sub", 32'd1, 32'd2, 3'd6, 32'd2, 5'd6, 4'b1000, 5'd4, 5'd5, 1, 2'b00, 2'b00));
        vec(st(0, 0, 0, 6'b100010, 2'b10, 32'd1, 32'd2, 32'h3F, 5'd4, 5'd5, 5'd6),
            ex("funct_other", 32'd1, 32'd2, 3'd2, 32'd2, 5'd6, 4'b1000, 5'd4, 5'd5, 1, 2'b00, 2'b00));
        // ALUOp 01 (branch compare), funct bits ignored
        vec(st(0, 0, 0, 6'b000000, 2'b01, 32'd1, 32'd2, 32'h24, 5'd4, 5'd5, 5'd6),
            ex("aluop_sub", 32'd1, 32'd2, 3'd6, 32'd2, 5'd5, 4'b0000, 5'd4, 5'd5, 1, 2'b00, 2'b00));
        // ALUOp 11 slti with immediate -1
        vec(st(0, 0, 0, 6'b100001, 2'b11, 32'd1, 32'd2, 32'hFFFF_FFFF, 5'd4, 5'd5, 5'd6),
            ex("aluop_slti", 32'd1, 32'hFFFF_FFFF, 3'd7, 32'd2, 5'd5, 4'b1000, 5'd4, 5'd5, 1, 2'b00, 2'b00));
        // reset mid-stream while stalled
        vec(st(1, 1, 0, 6'b111111, 2'b10, 32'd9, 32'd9, 32'h20, 5'd3, 5'd3, 5'd3),
            ex("reset_midstream", 0, 0, 3'd2, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 2'b00));

        repeat (2) @(negedge clk);
        drv_done = 1'b1;
    end

    // Summary once the scoreboard is drained, with a hard time bound
    initial begin
        fork
            begin
                wait (drv_done);
                #1;
                tests++;
                if (exp_q.size() != 0) begin
                    failed++;
                    $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
                end
            end
            begin
                #100000;
                tests++;
                failed++;
                $display("FAIL timeout actual=running required=done");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
